// File: rtl/buffer_pkgs.sv
// buffer_pkgs: shared writeback packet type, functional-unit ids and
// the ROB age helper used to decide which completions a recovery kills.
package buffer_pkgs;

  localparam int XLEN      = 32;
  localparam int ROB_TAG_W = 6;
  localparam int AGE_W     = 8;

  localparam logic [1:0] FU_ALU = 2'd0;
  localparam logic [1:0] FU_LSU = 2'd1;
  localparam logic [1:0] FU_BR  = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0]      data;
    logic [4:0]           rd_addr;
    logic                 rd_we;
    logic [ROB_TAG_W-1:0] ROB_tag;
    logic [1:0]           src_fu;
  } wb_packet_t;

  // Distance of tag from the ROB head, wrapped to ptr_w bits.
  function automatic logic [AGE_W-1:0] rob_age(
    input logic [AGE_W-1:0] tag,
    input logic [AGE_W-1:0] head,
    input int unsigned      ptr_w
  );
    logic [AGE_W-1:0] mask;
    mask = AGE_W'(((AGE_W+1)'(1) << ptr_w) - (AGE_W+1)'(1));
    return (tag - head) & mask;
  endfunction

endpackage

// File: rtl/wb_lane_fifo.sv
// wb_lane_fifo: per-lane completion buffer, head at entry 0.
// Ports: push/push_pkt, pop, kill (per-entry squash), head, full, empty,
// entries/vld (raw contents for the parent's age compare).
module wb_lane_fifo
  import buffer_pkgs::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push,
  input  wb_packet_t             push_pkt,
  input  logic                   pop,
  input  logic [DEPTH-1:0]       kill,
  output wb_packet_t             head,
  output logic                   full,
  output logic                   empty,
  output wb_packet_t [DEPTH-1:0] entries,
  output logic [DEPTH-1:0]       vld
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_packet_t [DEPTH-1:0] mem_q;
  logic [DEPTH-1:0]       vld_q;

  wb_packet_t [DEPTH-1:0] c_mem, p_mem, n_mem;
  logic [DEPTH-1:0]       c_vld, p_vld, n_vld;
  logic [IDX_W-1:0]       k;
  logic                   done;

  // Entries are kept packed from index 0, so the head is always slot 0
  // and full is simply the top slot being occupied.
  always_comb begin
    c_mem = '0;
    c_vld = '0;
    k     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && !kill[i]) begin
        c_mem[k] = mem_q[i];
        c_vld[k] = 1'b1;
        k        = k + 1'b1;
      end
    end

    p_mem = c_mem;
    p_vld = c_vld;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        p_mem[i] = c_mem[i+1];
        p_vld[i] = c_vld[i+1];
      end
      p_mem[DEPTH-1] = '0;
      p_vld[DEPTH-1] = 1'b0;
    end

    n_mem = p_mem;
    n_vld = p_vld;
    done  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (push && !done && !p_vld[i]) begin
        n_mem[i] = push_pkt;
        n_vld[i] = 1'b1;
        done     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q <= '0;
      vld_q <= '0;
    end else begin
      mem_q <= n_mem;
      vld_q <= n_vld;
    end
  end

  assign head    = mem_q[0];
  assign empty   = !vld_q[0];
  assign full    = vld_q[DEPTH-1];
  assign entries = mem_q;
  assign vld     = vld_q;

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU/LSU/BR completions into one registered
// writeback stream. BR has priority with a bounded streak, other lanes
// round-robin; a recovery squashes everything younger than the branch.
// Ports: req_valid_i/req_packet_i/req_ready_o per lane, wb_valid_o/
// wb_packet_o/wb_ready_i out, recover_i/recover_rob_tag_i/rob_head_i.
module wb_arbiter
  import buffer_pkgs::*;
#(
  parameter  int N_REQ         = 3,
  parameter  int BR_LANE       = 2,
  parameter  int FIFO_DEPTH    = 2,
  parameter  int BR_MAX_STREAK = 4,
  parameter  int ROB_DEPTH     = 16,
  localparam int ROB_PTR_W     = $clog2(ROB_DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_REQ-1:0]     req_valid_i,
  input  wb_packet_t           req_packet_i [N_REQ],
  output logic [N_REQ-1:0]     req_ready_o,
  output logic                 wb_valid_o,
  output wb_packet_t           wb_packet_o,
  input  logic                 wb_ready_i,
  input  logic                 recover_i,
  input  logic [ROB_PTR_W-1:0] recover_rob_tag_i,
  input  logic [ROB_PTR_W-1:0] rob_head_i
);

  localparam int LANE_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int STRK_W = $clog2(BR_MAX_STREAK + 1);

  function automatic logic younger(
    input wb_packet_t             p,
    input logic [ROB_PTR_W-1:0]   head,
    input logic [AGE_W-1:0]       ref_age
  );
    logic [AGE_W-1:0] a;
    a = rob_age(AGE_W'(p.ROB_tag[ROB_PTR_W-1:0]),
                AGE_W'(head), ROB_PTR_W);
    return a > ref_age;
  endfunction

  logic [AGE_W-1:0] rec_age;
  assign rec_age = rob_age(AGE_W'(recover_rob_tag_i),
                           AGE_W'(rob_head_i), ROB_PTR_W);

  wb_packet_t       head [N_REQ];
  logic [N_REQ-1:0] full, empty, push, pop;

  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    wb_packet_t [FIFO_DEPTH-1:0] ent;
    logic [FIFO_DEPTH-1:0]       ent_vld;
    logic [FIFO_DEPTH-1:0]       kill;
    logic                        in_young;

    for (genvar e = 0; e < FIFO_DEPTH; e++) begin : g_kill
      assign kill[e] = recover_i && ent_vld[e]
                    && younger(ent[e], rob_head_i, rec_age);
    end

    // Younger arrivals during recovery are handshaked but dropped.
    assign in_young = recover_i
                   && younger(req_packet_i[g], rob_head_i, rec_age);
    assign push[g]  = req_valid_i[g] && !full[g] && !in_young;

    wb_lane_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .push     (push[g]),
      .push_pkt (req_packet_i[g]),
      .pop      (pop[g]),
      .kill     (kill),
      .head     (head[g]),
      .full     (full[g]),
      .empty    (empty[g]),
      .entries  (ent),
      .vld      (ent_vld)
    );
  end

  assign req_ready_o = ~full;

  logic [LANE_W-1:0] rr_q, rr_gnt, rr_nxt, gnt_idx;
  logic [STRK_W-1:0] streak_q;
  logic [N_REQ-1:0]  nonbr;
  logic              br_req, other_req, br_win, rr_hit;
  logic              load_en, any_gnt, br_gnt;
  int                idx, nxt;

  always_comb begin
    nonbr          = ~empty;
    nonbr[BR_LANE] = 1'b0;
    br_req         = !empty[BR_LANE];
    other_req      = |nonbr;
    br_win         = br_req
                  && (streak_q < STRK_W'(BR_MAX_STREAK) || !other_req);
    load_en        = (!wb_valid_o || wb_ready_i) && !recover_i;

    rr_hit = 1'b0;
    rr_gnt = '0;
    idx    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_q) + i) % N_REQ;
      if (!rr_hit && nonbr[idx]) begin
        rr_hit = 1'b1;
        rr_gnt = LANE_W'(idx);
      end
    end

    // Next pointer never lands on the BR lane.
    nxt = (int'(rr_gnt) + 1) % N_REQ;
    if (nxt == BR_LANE) nxt = (nxt + 1) % N_REQ;
    rr_nxt = LANE_W'(nxt);

    pop     = '0;
    gnt_idx = rr_gnt;
    any_gnt = 1'b0;
    br_gnt  = 1'b0;
    if (load_en) begin
      if (br_win) begin
        pop[BR_LANE] = 1'b1;
        gnt_idx      = LANE_W'(BR_LANE);
        any_gnt      = 1'b1;
        br_gnt       = 1'b1;
      end else if (rr_hit) begin
        pop[rr_gnt]  = 1'b1;
        any_gnt      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_valid_o  <= 1'b0;
      wb_packet_o <= '0;
      rr_q        <= '0;
      streak_q    <= '0;
    end else if (recover_i) begin
      // Held packet drops if squashed, or leaves if consumed.
      if (wb_valid_o
          && (younger(wb_packet_o, rob_head_i, rec_age) || wb_ready_i))
        wb_valid_o <= 1'b0;
    end else begin
      if (load_en) begin
        wb_valid_o <= any_gnt;
        if (any_gnt) wb_packet_o <= head[gnt_idx];
      end
      if (br_gnt) begin
        if (streak_q != STRK_W'(BR_MAX_STREAK))
          streak_q <= streak_q + 1'b1;
      end else if (any_gnt) begin
        streak_q <= '0;
        rr_q     <= rr_nxt;
      end else if (!br_req) begin
        streak_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vectors for wb_arbiter with hand-computed
// expected writeback order, tags and handshake levels.
module tb_wb_arbiter;
  import buffer_pkgs::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req_valid;
  wb_packet_t req_pkt [3];
  logic [2:0] req_ready;
  logic       wb_valid;
  wb_packet_t wb_pkt;
  logic       wb_ready;
  logic       recover;
  logic [3:0] rec_tag;
  logic [3:0] rob_head;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_rr [4]  = '{1, 5, 2, 6};
  int exp_br [7]  = '{10, 11, 12, 13, 20, 14, 15};
  int rec [16];
  int nrec;
  int nt;
  logic acc;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .req_valid_i       (req_valid),
    .req_packet_i      (req_pkt),
    .req_ready_o       (req_ready),
    .wb_valid_o        (wb_valid),
    .wb_packet_o       (wb_pkt),
    .wb_ready_i        (wb_ready),
    .recover_i         (recover),
    .recover_rob_tag_i (rec_tag),
    .rob_head_i        (rob_head)
  );

  task automatic check_eq(input string tag,
                          input logic [63:0] got,
                          input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic wb_packet_t mk(input logic [1:0] fu,
                                    input int tag);
    wb_packet_t p;
    p         = '0;
    p.src_fu  = fu;
    p.ROB_tag = ROB_TAG_W'(tag);
    p.rd_addr = 5'(tag);
    p.rd_we   = 1'b1;
    p.data    = 32'hA000_0000 | (32'(fu) << 8) | 32'(tag);
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0;
    for (int i = 0; i < 3; i++) req_pkt[i] = '0;
  endtask

  // Leaves the bench in cycle 1 with reset released.
  task automatic reset_dut();
    idle();
    wb_ready = 1'b1;
    recover  = 1'b0;
    rec_tag  = '0;
    rob_head = '0;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
  endtask

  initial begin
    idle();
    wb_ready = 1'b1;
    recover  = 1'b0;
    rec_tag  = '0;
    rob_head = '0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", wb_valid, 0);
    check_eq("rst_pkt", wb_pkt, 0);
    check_eq("rst_ready", req_ready, 3'b111);

    // single ALU packet, tag 3
    reset_dut();
    req_valid[0] = 1'b1;
    req_pkt[0]   = mk(FU_ALU, 3);
    tick();
    idle();
    check_eq("t1_c2_valid", wb_valid, 0);
    tick();
    check_eq("t1_c3_valid", wb_valid, 1);
    check_eq("t1_c3_tag", wb_pkt.ROB_tag, 3);
    check_eq("t1_c3_fu", wb_pkt.src_fu, FU_ALU);
    tick();
    check_eq("t1_c4_valid", wb_valid, 0);

    // round-robin ALU/LSU
    reset_dut();
    req_valid  = 3'b011;
    req_pkt[0] = mk(FU_ALU, 1);
    req_pkt[1] = mk(FU_LSU, 5);
    tick();
    req_pkt[0] = mk(FU_ALU, 2);
    req_pkt[1] = mk(FU_LSU, 6);
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      check_eq("rr_valid", wb_valid, 1);
      check_eq("rr_tag", wb_pkt.ROB_tag, exp_rr[i]);
      tick();
    end
    check_eq("rr_drain", wb_valid, 0);

    // BR streak limit
    reset_dut();
    for (int cyc = 1; cyc <= 10; cyc++) begin
      idle();
      if (cyc <= 6) begin
        req_valid[2] = 1'b1;
        req_pkt[2]   = mk(FU_BR, 9 + cyc);
      end
      if (cyc == 1) begin
        req_valid[0] = 1'b1;
        req_pkt[0]   = mk(FU_ALU, 20);
      end
      if (cyc >= 3 && cyc <= 9) begin
        check_eq("br_valid", wb_valid, 1);
        check_eq("br_tag", wb_pkt.ROB_tag, exp_br[cyc-3]);
      end
      if (cyc == 10) check_eq("br_drain", wb_valid, 0);
      tick();
    end
    idle();

    // backpressure on ALU stream
    reset_dut();
    nt   = 30;
    acc  = 1'b0;
    nrec = 0;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      if (acc) nt++;
      wb_ready     = (cyc >= 8);
      req_valid[0] = (nt <= 35);
      req_pkt[0]   = mk(FU_ALU, nt);
      acc          = req_valid[0] && req_ready[0];
      if (cyc >= 3 && cyc <= 7) begin
        check_eq("bp_hold_valid", wb_valid, 1);
        check_eq("bp_hold_tag", wb_pkt.ROB_tag, 30);
      end
      if (cyc == 4) check_eq("bp_full", req_ready[0], 0);
      if (cyc == 9) check_eq("bp_reready", req_ready[0], 1);
      if (wb_valid && wb_ready) begin
        if (nrec < 16) rec[nrec] = int'(wb_pkt.ROB_tag);
        nrec++;
      end
      tick();
    end
    idle();
    check_eq("bp_count", nrec, 6);
    for (int i = 0; i < 6 && i < nrec; i++)
      check_eq("bp_order", rec[i], 30 + i);

    // recovery with ROB wrap: head 14, branch 15
    reset_dut();
    rob_head   = 4'd14;
    wb_ready   = 1'b0;
    req_valid  = 3'b111;
    req_pkt[0] = mk(FU_ALU, 14);
    req_pkt[1] = mk(FU_LSU, 15);
    req_pkt[2] = mk(FU_BR, 14);
    tick();
    req_valid  = 3'b011;
    req_pkt[0] = mk(FU_ALU, 0);
    req_pkt[1] = mk(FU_LSU, 1);
    tick();
    idle();
    check_eq("wrap_c3_fu", wb_pkt.src_fu, FU_BR);
    recover = 1'b1;
    rec_tag = 4'd15;
    tick();
    recover = 1'b0;
    check_eq("wrap_hold_valid", wb_valid, 1);
    check_eq("wrap_hold_tag", wb_pkt.ROB_tag, 14);
    check_eq("wrap_ready", req_ready, 3'b111);
    wb_ready = 1'b1;
    tick();
    check_eq("wrap_alu_tag", wb_pkt.ROB_tag, 14);
    check_eq("wrap_alu_fu", wb_pkt.src_fu, FU_ALU);
    tick();
    check_eq("wrap_lsu_tag", wb_pkt.ROB_tag, 15);
    check_eq("wrap_lsu_fu", wb_pkt.src_fu, FU_LSU);
    tick();
    check_eq("wrap_drain", wb_valid, 0);

    // recovery hitting the output register
    reset_dut();
    rob_head     = 4'd2;
    wb_ready     = 1'b0;
    req_valid[0] = 1'b1;
    req_pkt[0]   = mk(FU_ALU, 5);
    tick();
    idle();
    tick();
    check_eq("ro_c3_valid", wb_valid, 1);
    check_eq("ro_c3_tag", wb_pkt.ROB_tag, 5);
    recover    = 1'b1;
    rec_tag    = 4'd4;
    req_valid  = 3'b110;
    req_pkt[1] = mk(FU_LSU, 6);
    req_pkt[2] = mk(FU_BR, 4);
    tick();
    idle();
    recover = 1'b0;
    check_eq("ro_squash", wb_valid, 0);
    tick();
    check_eq("ro_br_valid", wb_valid, 1);
    check_eq("ro_br_tag", wb_pkt.ROB_tag, 4);
    wb_ready = 1'b1;
    tick();
    check_eq("ro_drop_young", wb_valid, 0);

    // asynchronous reset mid-cycle
    reset_dut();
    wb_ready     = 1'b0;
    req_valid[0] = 1'b1;
    req_pkt[0]   = mk(FU_ALU, 7);
    tick();
    idle();
    tick();
    check_eq("ar_pre_valid", wb_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("ar_valid", wb_valid, 0);
    check_eq("ar_pkt", wb_pkt, 0);
    check_eq("ar_ready", req_ready, 3'b111);
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
